// File: rtl/spm_arb_pkg.sv
// Shared defaults and FSM state type for the scratch-pad memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spm_arb_pkg;

    localparam int SPM_ADDR_W  = 10;
    localparam int SPM_DATA_W  = 16;
    localparam int SPM_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
// Latency: combinational.
// Backpressure: none; the caller decides when a grant is consumed.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // One-hot grant; i_last_grant=1 means requester 1 won the previous grant
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/spm_arbiter.sv
// Arbitrates two requesters onto one single-port memory (IDLE/BUSY/DONE FSM); SPM_ARB_TIMEOUT_EN adds a BUSY abort.
// Latency: accept cycle 0, mem_valid from cycle 1 until mem_ready, done pulse the cycle after mem_ready.
// Backpressure: requesters hold valid until their done; one transaction in flight, mem_ready waited on indefinitely unless timeout built in.
module spm_arbiter
    import spm_arb_pkg::*;
#(
    parameter int ADDR_W  = SPM_ADDR_W,
    parameter int DATA_W  = SPM_DATA_W,
    parameter int TIMEOUT = SPM_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rq0_valid,
    input  logic              rq1_valid,
    input  logic              rq0_wr,
    input  logic              rq1_wr,
    input  logic [ADDR_W-1:0] rq0_addr,
    input  logic [ADDR_W-1:0] rq1_addr,
    input  logic [DATA_W-1:0] rq0_wdata,
    input  logic [DATA_W-1:0] rq1_wdata,
    output logic              rq0_done,
    output logic              rq1_done,
    output logic [DATA_W-1:0] rq0_rdata,
    output logic [DATA_W-1:0] rq1_rdata,
    output logic              rq0_err,
    output logic              rq1_err,
    output logic              mem_valid,
    output logic              mem_WR,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic              mem_ready
);

    state_t              r_state;
    logic                r_last_grant;
    logic                r_gnt_idx;
    logic                r_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_mem_valid;
    logic                r_done0;
    logic                r_done1;
    logic [DATA_W-1:0]   r_rdata0;
    logic [DATA_W-1:0]   r_rdata1;
    logic                r_err0;
    logic                r_err1;

    logic [1:0]          w_grant;
    logic                w_timeout;
    logic                w_finish;
    logic                w_err_nxt;
    logic [DATA_W-1:0]   w_rdata_nxt;

    rr_arb2 u_rr_arb2 (
        .i_req        ({rq1_valid, rq0_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

`ifdef SPM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    // The last allowed BUSY cycle is the one where the counter reads TIMEOUT-1
    assign w_timeout = (r_state == BUSY) && (r_cnt == CNT_W'(TIMEOUT - 1));

    // Count BUSY cycles; cleared while idle so every transaction starts from zero
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end
`else
    localparam int lp_unused_timeout = TIMEOUT;

    assign w_timeout = 1'b0;
`endif

    // mem_ready wins over a coincident timeout; writes and aborts return zero data
    assign w_finish    = mem_ready || w_timeout;
    assign w_err_nxt   = w_timeout && !mem_ready;
    assign w_rdata_nxt = (mem_ready && !r_wr) ? mem_data_out : '0;

    // Main FSM: grant and latch in IDLE, hold the command in BUSY, pulse done in DONE
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_gnt_idx    <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mem_valid  <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_rdata0     <= '0;
            r_rdata1     <= '0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_gnt_idx    <= w_grant[1];
                        r_last_grant <= w_grant[1];
                        r_wr         <= w_grant[1] ? rq1_wr    : rq0_wr;
                        r_addr       <= w_grant[1] ? rq1_addr  : rq0_addr;
                        r_wdata      <= w_grant[1] ? rq1_wdata : rq0_wdata;
                        r_mem_valid  <= 1'b1;
                        r_state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (w_finish) begin
                        r_mem_valid <= 1'b0;
                        r_state     <= DONE;
                        if (r_gnt_idx) begin
                            r_done1  <= 1'b1;
                            r_rdata1 <= w_rdata_nxt;
                            r_err1   <= w_err_nxt;
                        end else begin
                            r_done0  <= 1'b1;
                            r_rdata0 <= w_rdata_nxt;
                            r_err0   <= w_err_nxt;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_mem_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign rq0_done    = r_done0;
    assign rq1_done    = r_done1;
    assign rq0_rdata   = r_rdata0;
    assign rq1_rdata   = r_rdata1;
    assign rq0_err     = r_err0;
    assign rq1_err     = r_err1;
    assign mem_valid   = r_mem_valid;
    assign mem_WR      = r_wr;
    assign mem_addr    = r_addr;
    assign mem_data_in = r_wdata;

endmodule

// File: doc/spm_arbiter.md
SPM_ARBITER -- requirements
Module: spm_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, memory address width.
REQ-002 Parameter DATA_W, default 16, memory data width.
REQ-003 Parameter TIMEOUT, default 15, max BUSY cycles before abort (used only with SPM_ARB_TIMEOUT_EN).
REQ-004 Ports SHALL be, clock and reset first:
 clk  in  1  single clock, rising-edge;
 reset  in  1  synchronous, active-low reset;
 rq0_valid, rq1_valid  in  1  request pending, held until matching done;
 rq0_wr, rq1_wr  in  1  1=write, 0=read;
 rq0_addr, rq1_addr  in  ADDR_W  request address;
 rq0_wdata, rq1_wdata  in  DATA_W  write data;
 rq0_done, rq1_done  out  1  one-cycle completion pulse;
 rq0_rdata, rq1_rdata  out  DATA_W  read data, valid with done;
 rq0_err, rq1_err  out  1  timeout flag, valid with done;
 mem_valid  out  1  memory command valid;
 mem_WR  out  1  memory write enable;
 mem_addr  out  ADDR_W  memory address;
 mem_data_in  out  DATA_W  memory write data;
 mem_data_out  in  DATA_W  memory read data;
 mem_ready  in  1  memory completion.

Function
REQ-005 FSM states SHALL be IDLE, BUSY, DONE.
REQ-006 IDLE: no rqN_valid -> stay; else grant one requester, latch its wr/addr/wdata, go BUSY next cycle.
REQ-007 Arbitration SHALL be round-robin: single requester always wins; both valid -> grant the one not granted last; last_grant updates on every grant.
REQ-008 BUSY: mem_valid=1, mem_WR/mem_addr/mem_data_in driven from latched command, stable throughout BUSY.
REQ-009 BUSY with mem_ready=1 at a rising edge -> DONE; for reads, mem_data_out sampled at that edge into granted requester's rdata register.
REQ-010 DONE: granted rqN_done=1 for exactly one cycle, rqN_rdata valid (0 for writes), mem_valid=0; DONE -> IDLE unconditionally.
REQ-011 No arbitration in BUSY or DONE; requests arriving then wait for IDLE.
REQ-012 With memory returning mem_ready the cycle after mem_valid: accept in IDLE cycle 0, mem_valid cycles 1-2, done cycle 3; back-to-back throughput one transaction per 4 cycles.
REQ-013 Non-granted requester's done/rdata/err SHALL hold 0/previous value/0.
REQ-014 mem_ready outside BUSY SHALL be ignored.
REQ-015 Requester lowering valid before done is illegal; behaviour then is undefined but FSM SHALL still return to IDLE.

Reset
REQ-016 reset=0 at a rising edge SHALL force IDLE, last_grant=1 (requester 0 wins first tie), all outputs 0, rdata registers 0, timeout counter 0.
REQ-017 Reset in BUSY or DONE SHALL abort the transaction; no done pulse issued; mem_valid 0 in the next cycle.

Configuration
REQ-018 Macro SPM_ARB_TIMEOUT_EN defined: counter increments each BUSY cycle; TIMEOUT cycles without mem_ready -> DONE with rqN_err=1, rqN_rdata=0; counter cleared on entering BUSY.
REQ-019 Macro undefined: no counter; BUSY waits indefinitely; rq0_err/rq1_err tied 0.

Structure
REQ-020 Package spm_arb_pkg SHALL hold ADDR_W/DATA_W/TIMEOUT defaults and the state typedef (IDLE, BUSY, DONE).
REQ-021 Sub-module rr_arb2 SHALL implement 2-way round-robin grant (inputs req[1:0], last_grant, output grant one-hot); the rest is spm_arbiter.

Verification
REQ-022 Reset held 2 cycles with rq0_valid=1 -> no mem_valid, no done; release -> rq0 granted first.
REQ-023 rq0 write addr 5 data 16'hA5A5, then rq1 read addr 5 with 1-cycle memory -> rq1_done at cycle 3 of its transaction, rq1_rdata=16'hA5A5.
REQ-024 Both valid continuously, 4 transactions -> grants alternate 0,1,0,1; each done one cycle, one per 4 cycles.
REQ-025 Reset asserted mid-BUSY -> IDLE next cycle, mem_valid=0, no done pulse.
REQ-026 SPM_ARB_TIMEOUT_EN, mem_ready held 0 -> done after 15 BUSY cycles with err=1, rdata=0; without macro, no done after 100 cycles.
